// File: rtl/or4_share_arbiter.sv
// Time-shares one 74x32 quad 2-input OR among NUM_REQ requesters (round-robin, or fixed priority with OR4_SHARE_ARB_FIXED_PRIO_EN).
// Latency: grant on the edge a request is seen in IDLE; ack and res appear SETTLE_CYCLES+1 cycles later.
// Backpressure: one operation in flight; other requests wait until the next IDLE cycle; min turnaround SETTLE_CYCLES+2.
module or4_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] a_in,
    input  logic [4*NUM_REQ-1:0] b_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic [3:0]           res,
    output logic                 busy,
    output logic [3:0]           or_a,
    output logic [3:0]           or_b,
    input  logic [3:0]           or_y
);
    localparam int                 PTR_W    = $clog2(NUM_REQ);
    localparam int                 IDX_W    = PTR_W + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   NUM_IDX  = IDX_W'(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST     = PTR_W'(NUM_REQ - 1);
    localparam logic [3:0]         CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] start;
    logic [IDX_W-1:0] idx;
    logic             found;

`ifdef OR4_SHARE_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign start = '0;
`else
    logic [PTR_W-1:0] ptr;

    assign start = ptr;

    // Rotate the search start to just past the requester that was served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == CAPTURE) begin
            ptr <= (win == LAST) ? '0 : win + 1'b1;
        end
    end
`endif

    // Find the first set request at or after the start index, wrapping past NUM_REQ-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, start} + IDX_W'(i);
            if (idx >= NUM_IDX) begin
                idx = idx - NUM_IDX;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE always lasts at least one cycle, SETTLE runs until cnt hits zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Operand drive, settle counter, result capture and the one-cycle ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt  <= '0;
            ack  <= '0;
            res  <= '0;
            or_a <= '0;
            or_b <= '0;
            cnt  <= '0;
            win  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        or_a <= a_in[{pick, 2'b00} +: 4];
                        or_b <= b_in[{pick, 2'b00} +: 4];
                        gnt  <= ONE_HOT0 << pick;
                        win  <= pick;
                        cnt  <= CNT_LOAD;
                    end else begin
                        or_a <= '0;
                        or_b <= '0;
                        gnt  <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    res  <= or_y;
                    ack  <= ONE_HOT0 << win;
                    gnt  <= '0;
                    or_a <= '0;
                    or_b <= '0;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_or4_share_arbiter.sv
// Bench for or4_share_arbiter: directed vector table, multi-cycle corner sequences and random traffic.
// A transaction-level reference model predicts every output after every clock edge.
// The shared 74x32 is modelled as a zero-delay OR of or_a and or_b.
module tb_or4_share_arbiter;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [4*N-1:0] a_in;
    logic [4*N-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [3:0]     res;
    logic           busy;
    logic [3:0]     or_a;
    logic [3:0]     or_b;
    logic [3:0]     or_y;

    int checks;
    int errors;

    or4_share_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .gnt  (gnt),
        .ack  (ack),
        .res  (res),
        .busy (busy),
        .or_a (or_a),
        .or_b (or_b),
        .or_y (or_y)
    );

    assign or_y = or_a | or_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    int           m_left;   // cycles until the current operation acks; 0 = idle
    int           m_win;
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_ack;
    logic [3:0]   m_res;
    logic [3:0]   m_ora;
    logic [3:0]   m_orb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_win  = 0;
        m_ptr  = 0;
        m_gnt  = '0;
        m_ack  = '0;
        m_res  = '0;
        m_ora  = '0;
        m_orb  = '0;
    endtask

    task automatic model_step();
        logic [N-1:0]   one;
        logic [N-1:0]   sh;
        logic [4*N-1:0] sl;
        one   = 1;
        m_ack = '0;
        if (m_left == 0) begin
            if (req != '0) begin
                m_win = -1;
                for (int off = 0; off < N; off++) begin
                    int k;
                    k  = (m_ptr + off) % N;
                    sh = req >> k;
                    if (m_win < 0 && sh[0]) m_win = k;
                end
                sl     = a_in >> (4 * m_win);
                m_ora  = sl[3:0];
                sl     = b_in >> (4 * m_win);
                m_orb  = sl[3:0];
                m_gnt  = one << m_win;
                m_left = S + 1;
            end else begin
                m_gnt = '0;
                m_ora = '0;
                m_orb = '0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_res = m_ora | m_orb;
                m_ack = one << m_win;
                m_gnt = '0;
                m_ora = '0;
                m_orb = '0;
`ifndef OR4_SHARE_ARB_FIXED_PRIO_EN
                m_ptr = (m_win + 1) % N;
`endif
            end
        end
    endtask

    task automatic model_check();
        chk("mdl_gnt", gnt, m_gnt);
        chk("mdl_ack", ack, m_ack);
        chk("mdl_res", res, m_res);
        chk("mdl_or_a", or_a, m_ora);
        chk("mdl_or_b", or_b, m_orb);
        chk("mdl_busy", busy, m_left != 0);
    endtask

    // One clock: advance the model on the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]   req;
        logic [4*N-1:0] a;
        logic [4*N-1:0] b;
        logic [N-1:0]   gnt;
        logic [3:0]     res;
    } vec_t;

    vec_t vec[7];

    int   exp_order[5];
    logic [3:0] exp_rr_res[5];
    int   got;
    int   last_t;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        a_in   = '0;
        b_in   = '0;
        model_reset();

        vec[0] = '{4'b0001, 16'h000A, 16'h0005, 4'b0001, 4'hF};
        vec[1] = '{4'b0010, 16'hF01F, 16'h0F2F, 4'b0010, 4'h3};
        vec[2] = '{4'b0100, 16'h0800, 16'h0400, 4'b0100, 4'hC};
        vec[3] = '{4'b1000, 16'h0000, 16'h0000, 4'b1000, 4'h0};
        vec[4] = '{4'b1000, 16'h5000, 16'h1000, 4'b1000, 4'h5};
        vec[5] = '{4'b0001, 16'hFFF0, 16'hFFF0, 4'b0001, 4'h0};
        vec[6] = '{4'b0010, 16'h0090, 16'h0060, 4'b0010, 4'hF};

        // Reset state
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_res", res, 0);
        chk("rst_busy", busy, 0);
        chk("rst_or_a", or_a, 0);
        chk("rst_or_b", or_b, 0);
        tick();
        rst_n = 1'b1;

        // Single isolated requests from the table
        for (int v = 0; v < 7; v++) begin
            req  = vec[v].req;
            a_in = vec[v].a;
            b_in = vec[v].b;
            tick();
            chk("tbl_gnt", gnt, vec[v].gnt);
            chk("tbl_busy", busy, 1);
            req = '0;
            for (int c = 0; c < S; c++) begin
                tick();
                chk("tbl_gnt_hold", gnt, vec[v].gnt);
                chk("tbl_no_ack", ack, 0);
            end
            tick();
            chk("tbl_ack", ack, vec[v].gnt);
            chk("tbl_res", res, vec[v].res);
            chk("tbl_gnt_clear", gnt, 0);
            tick();
            chk("tbl_ack_clear", ack, 0);
            chk("tbl_res_hold", res, vec[v].res);
        end

        // All four requesting continuously
`ifdef OR4_SHARE_ARB_FIXED_PRIO_EN
        exp_order  = '{0, 0, 0, 0, 0};
        exp_rr_res = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
`else
        exp_order  = '{0, 1, 2, 3, 0};
        exp_rr_res = '{4'h3, 4'h3, 4'h5, 4'h9, 4'h3};
`endif
        do_reset();
        req    = 4'b1111;
        a_in   = 16'h8421;
        b_in   = 16'h1112;
        got    = 0;
        last_t = 0;
        for (int t = 1; t <= 40 && got < 5; t++) begin
            tick();
            if (ack != '0) begin
                chk("rr_ack_order", ack, 32'd1 << exp_order[got]);
                chk("rr_res", res, exp_rr_res[got]);
                if (got > 0) chk("rr_ack_spacing", t - last_t, S + 2);
                last_t = t;
                got++;
            end
        end
        chk("rr_ack_count", got, 5);
        req = '0;
        for (int c = 0; c < S + 2; c++) tick();

        // Operand change after grant is ignored
        do_reset();
        req  = 4'b0010;
        a_in = 16'h0080;
        b_in = 16'h0010;
        tick();
        chk("opchg_gnt", gnt, 4'b0010);
        chk("opchg_or_a", or_a, 4'h8);
        a_in = 16'h0000;
        req  = '0;
        for (int c = 0; c < S; c++) begin
            tick();
            chk("opchg_or_a_hold", or_a, 4'h8);
        end
        tick();
        chk("opchg_ack", ack, 4'b0010);
        chk("opchg_res", res, 4'h9);

        // Request dropped mid-operation, pointer still advances
        do_reset();
        req  = 4'b0100;
        a_in = 16'h0300;
        b_in = 16'h0400;
        tick();
        tick();
        req = '0;
        tick();
        tick();
        chk("drop_ack", ack, 4'b0100);
        chk("drop_res", res, 4'h7);
        req = 4'b1001;
        tick();
`ifdef OR4_SHARE_ARB_FIXED_PRIO_EN
        chk("drop_next_gnt", gnt, 4'b0001);
`else
        chk("drop_next_gnt", gnt, 4'b1000);
`endif
        req = '0;
        for (int c = 0; c < S + 2; c++) tick();

        // Reset in the middle of an operation
        do_reset();
        req  = 4'b0001;
        a_in = 16'h0051;
        b_in = 16'h0002;
        tick();
        req = '0;
        for (int c = 0; c < S + 1; c++) tick();
        chk("mrst_pre_res", res, 4'h3);
        req = 4'b0010;
        tick();
        tick();
        chk("mrst_busy_before", busy, 1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        model_reset();
        chk("mrst_gnt", gnt, 0);
        chk("mrst_ack", ack, 0);
        chk("mrst_or_a", or_a, 0);
        chk("mrst_or_b", or_b, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_res", res, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mrst_no_ack", ack, 0);
        end

        // Random traffic against the model, with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = '0;
            else req = N'($urandom_range(0, 15));
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
